// File: rtl/adder_pkg.sv
// Shared definitions for the digit-serial adder: FSM encoding, counter sizing
// and an elaboration-time parameter check.
package adder_pkg;

  typedef enum logic {
    STATE_IDLE = 1'b0,
    STATE_RUN  = 1'b1
  } state_t;

  // One spare bit keeps the counter legal when STEPS is a power of two or 1.
  function automatic int step_cnt_width(input int steps);
    return $clog2(steps) + 1;
  endfunction

endpackage

`define ADDER_PARAM_CHECK(W, D) \
  if ((D) < 1 || (D) > (W) || ((W) % (D)) != 0) begin : g_param_check \
    $error("serial_adder: WIDTH must be a positive multiple of DIGIT"); \
  end

// File: rtl/digit_adder.sv
// Combinational DIGIT-bit ripple adder built from chained 1-bit full-adder equations.
module digit_adder #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             c_in,
  output logic [DIGIT-1:0] s,
  output logic             c_out
);

  logic [DIGIT:0] c;

  assign c[0] = c_in;

  for (genvar gi = 0; gi < DIGIT; gi++) begin : g_fa
    assign s[gi]   = a[gi] ^ b[gi] ^ c[gi];
    assign c[gi+1] = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
  end

  assign c_out = c[DIGIT];

endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: WIDTH-bit operands consumed DIGIT bits per clock
// with a registered inter-digit carry and a start/busy/done handshake.
module serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int DIGIT       = 4,
  parameter bit SUBTRACT_EN = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] augend,
  input  logic [WIDTH-1:0] addend,
  input  logic             carry_in,
  input  logic             subtract,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW    = step_cnt_width(STEPS);

  `ADDER_PARAM_CHECK(WIDTH, DIGIT)

  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] a_reg, b_reg, res_reg;
  logic             carry_reg;
  logic             a_msb_reg, b_msb_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             carry_out_reg, overflow_reg, done_reg;

  logic             sub_eff;
  logic [WIDTH-1:0] b_eff;
  logic [DIGIT-1:0] dig_s;
  logic             dig_c;
  logic [WIDTH-1:0] dig_ext, res_next;
  logic             last_step;

  assign sub_eff   = SUBTRACT_EN && subtract;
  assign b_eff     = sub_eff ? ~addend : addend;
  assign last_step = (cnt_reg == CW'(STEPS - 1));

  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .a     (a_reg[DIGIT-1:0]),
    .b     (b_reg[DIGIT-1:0]),
    .c_in  (carry_reg),
    .s     (dig_s),
    .c_out (dig_c)
  );

  // New digit enters at the MSB end so the LSB digit lands at the bottom after STEPS shifts.
  assign dig_ext  = WIDTH'(dig_s);
  assign res_next = (res_reg >> DIGIT) | (dig_ext << (WIDTH - DIGIT));

  always_ff @(posedge clock) begin
    if (reset) state_reg <= STATE_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      STATE_IDLE: if (start)     state_next = STATE_RUN;
      STATE_RUN:  if (last_step) state_next = STATE_IDLE;
      default:                   state_next = STATE_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_reg       <= '0;
      a_reg         <= '0;
      b_reg         <= '0;
      res_reg       <= '0;
      carry_reg     <= 1'b0;
      a_msb_reg     <= 1'b0;
      b_msb_reg     <= 1'b0;
      sum_reg       <= '0;
      carry_out_reg <= 1'b0;
      overflow_reg  <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        STATE_IDLE: begin
          if (start) begin
            a_reg     <= augend;
            b_reg     <= b_eff;
            carry_reg <= sub_eff ? 1'b1 : carry_in;
            cnt_reg   <= '0;
            a_msb_reg <= augend[WIDTH-1];
            b_msb_reg <= b_eff[WIDTH-1];
          end
        end
        STATE_RUN: begin
          res_reg   <= res_next;
          carry_reg <= dig_c;
          a_reg     <= a_reg >> DIGIT;
          b_reg     <= b_reg >> DIGIT;
          cnt_reg   <= cnt_reg + CW'(1);
          if (last_step) begin
            sum_reg       <= res_next;
            carry_out_reg <= dig_c;
            overflow_reg  <= (a_msb_reg == b_msb_reg) && (res_next[WIDTH-1] != a_msb_reg);
            done_reg      <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy     = (state_reg == STATE_RUN);
  assign done     = done_reg;
  assign sum      = sum_reg;
  assign carry    = carry_out_reg;
  assign overflow = overflow_reg;

endmodule
